ysyx_22041207_mdu: RTL and testbench

Parametrised iterative multiply/divide unit for the RV64M/RV32M extension. It executes all eight M-extension operations, plus the word variants when enabled, using radix-2 shift-add multiplication and restoring division. Operands enter and results leave through valid/ready handshakes, which replaces the ad-hoc `alu_wait` stall. It sits beside the single-cycle ALU in the execute stage and takes the flush from the pipeline controller.

---
 rtl/ysyx_22041207_mdu_pkg.sv | 20 ++
 rtl/ysyx_22041207_mdu_sign.sv | 59 +++++
 rtl/ysyx_22041207_mdu.sv | 146 ++++++++++++++
 tb/tb_ysyx_22041207_mdu.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041207_mdu_pkg.sv
// Shared definitions for the iterative RV64M/RV32M multiply/divide unit:
// op encoding, FSM state type and the most-negative-value helper.
package ysyx_22041207_mdu_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  function automatic logic [63:0] min_val(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/ysyx_22041207_mdu_sign.sv
// Operand magnitude/sign extraction and result sign fix-up/selection,
// shared by the multiply and divide datapaths.
import ysyx_22041207_mdu_pkg::*;

module ysyx_22041207_mdu_sign #(
  parameter int XLEN = 64
) (
  input  logic [2:0]        op,
  input  logic              word,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   a_mag,
  output logic [XLEN-1:0]   b_mag,
  output logic              a_neg,
  output logic              b_neg,
  input  logic [2:0]        res_op,
  input  logic              res_word,
  input  logic              res_neg,
  input  logic              rem_neg,
  input  logic [2*XLEN-1:0] prod,
  input  logic [XLEN-1:0]   quot,
  input  logic [XLEN-1:0]   rem,
  output logic [XLEN-1:0]   res
);

  logic              a_sgn, b_sgn;
  logic [XLEN-1:0]   a_ext, b_ext;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s, rem_s;

  always_comb begin
    a_sgn = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
            (op == OP_DIV) || (op == OP_REM);
    b_sgn = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_ext = a;
    b_ext = b;
    if (word) begin
      a_ext = a_sgn ? XLEN'($signed(a[31:0])) : XLEN'(a[31:0]);
      b_ext = b_sgn ? XLEN'($signed(b[31:0])) : XLEN'(b[31:0]);
    end
    a_neg = a_sgn && a_ext[XLEN-1];
    b_neg = b_sgn && b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
  end

  always_comb begin
    prod_s = res_neg ? -prod : prod;
    quot_s = res_neg ? -quot : quot;
    rem_s  = rem_neg ? -rem  : rem;
    case (res_op)
      OP_MUL:                       res = res_word ? XLEN'($signed(prod_s[31:0])) : prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              res = res_word ? XLEN'($signed(quot_s[31:0])) : quot_s;
      default:                      res = res_word ? XLEN'($signed(rem_s[31:0])) : rem_s;
    endcase
  end

endmodule

// File: rtl/ysyx_22041207_mdu.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// valid/ready on both sides.
//   state  | meaning
//   S_IDLE | waiting for a request, in_ready high
//   S_BUSY | one multiply/divide iteration per cycle
//   S_DONE | result held on res with out_valid until out_ready
import ysyx_22041207_mdu_pkg::*;

module ysyx_22041207_mdu #(
  parameter int XLEN  = 64,
  parameter int W_OPS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res
);

  localparam int              CW      = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_VAL = XLEN'(min_val(XLEN));
  localparam logic [XLEN-1:0] ONES    = '1;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic              word_q, neg_q, rneg_q;
  logic [XLEN-1:0]   mul_a, mul_a_n;
  logic [2*XLEN-1:0] mul_b, mul_b_n, acc, acc_n;
  logic              word_eff, b_zero, ovf;
  logic [XLEN-1:0]   a_mag, b_mag, fast_res, fix_res;
  logic              a_neg, b_neg;
  logic [XLEN:0]     r_sh, diff;

  assign in_ready = (state == S_IDLE);
  assign word_eff = (W_OPS != 0) && (XLEN == 64) && word &&
                    !(op inside {OP_MULH, OP_MULHSU, OP_MULHU});
  assign b_zero   = word_eff ? (b[31:0] == 32'd0) : (b == '0);
  assign ovf      = ((op == OP_DIV) || (op == OP_REM)) &&
                    (word_eff ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                              : (a == MIN_VAL && b == ONES));

  always_comb begin
    fast_res = ONES;
    if (b_zero) begin
      if (op[1]) fast_res = word_eff ? XLEN'($signed(a[31:0])) : a;
    end else if (op[1]) begin
      fast_res = '0;
    end else begin
      fast_res = word_eff ? XLEN'($signed(32'h8000_0000)) : MIN_VAL;
    end
  end

  // Divide: mul_a shifts dividend bits out and quotient bits in, acc holds the
  // partial remainder, mul_b the divisor. A clear top bit of diff means no borrow.
  always_comb begin
    r_sh = {acc[XLEN-1:0], mul_a[XLEN-1]};
    diff = r_sh - {1'b0, mul_b[XLEN-1:0]};
    if (op_q[2]) begin
      acc_n   = {{XLEN{1'b0}}, diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0]};
      mul_a_n = {mul_a[XLEN-2:0], !diff[XLEN]};
      mul_b_n = mul_b;
    end else begin
      acc_n   = acc + (mul_a[0] ? mul_b : '0);
      mul_a_n = mul_a >> 1;
      mul_b_n = mul_b << 1;
    end
  end

  ysyx_22041207_mdu_sign #(.XLEN(XLEN)) u_sign (
    .op(op), .word(word_eff), .a(a), .b(b),
    .a_mag(a_mag), .b_mag(b_mag), .a_neg(a_neg), .b_neg(b_neg),
    .res_op(op_q), .res_word(word_q), .res_neg(neg_q), .rem_neg(rneg_q),
    .prod(acc_n), .quot(mul_a_n), .rem(acc_n[XLEN-1:0]), .res(fix_res)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      res       <= '0;
      op_q      <= OP_MUL;
      word_q    <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      acc       <= '0;
    end else if (flush) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          op_q   <= op;
          word_q <= word_eff;
          neg_q  <= a_neg ^ b_neg;
          rneg_q <= a_neg;
          acc    <= '0;
          cnt    <= word_eff ? CW'(32) : CW'(XLEN);
          if (op[2]) begin
            // word dividends are pre-aligned so only 32 steps are needed
            mul_a <= word_eff ? (a_mag << 32) : a_mag;
            mul_b <= {{XLEN{1'b0}}, b_mag};
          end else begin
            mul_a <= b_mag;
            mul_b <= {{XLEN{1'b0}}, a_mag};
          end
          if (op[2] && (b_zero || ovf)) begin
            res       <= fast_res;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          acc   <= acc_n;
          mul_a <= mul_a_n;
          mul_b <= mul_b_n;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            res       <= fix_res;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041207_mdu.sv
// Scoreboard bench for ysyx_22041207_mdu: directed corner cases, backpressure,
// flush and reset, then randomized traffic against an arithmetic reference model.
module tb_ysyx_22041207_mdu;

  localparam logic [63:0] ALL1  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, word, out_valid, out_ready;
  logic [2:0]  op;
  logic [63:0] a, b, res;

  ysyx_22041207_mdu #(.XLEN(64), .W_OPS(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .word(word), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .res(res)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] res;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [2:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
  } req_t;

  bit rand_ready = 0;
  bit prev_valid = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_word(input logic [2:0] o, input logic w);
    return w && (o == 3'd0 || o >= 3'd4);
  endfunction

  function automatic logic [63:0] model(input logic [2:0] o, input logic w,
                                        input logic [63:0] x, input logic [63:0] y);
    logic [127:0] p;
    logic [31:0]  r32, ux, uy;
    int           sx32, sy32;
    longint       sx, sy;
    bit           ov32, ov64;
    ux = x[31:0]; uy = y[31:0];
    sx32 = x[31:0]; sy32 = y[31:0];
    sx = x; sy = y;
    ov32 = (ux == 32'h8000_0000) && (uy == 32'hFFFF_FFFF);
    ov64 = (x == MIN64) && (y == ALL1);
    if (is_word(o, w)) begin
      case (o)
        3'd0:    r32 = ux * uy;
        3'd4:    r32 = (uy == 0) ? 32'hFFFF_FFFF : ov32 ? 32'h8000_0000 : 32'(sx32 / sy32);
        3'd5:    r32 = (uy == 0) ? 32'hFFFF_FFFF : ux / uy;
        3'd6:    r32 = (uy == 0) ? ux : ov32 ? 32'd0 : 32'(sx32 % sy32);
        default: r32 = (uy == 0) ? ux : ux % uy;
      endcase
      return {{32{r32[31]}}, r32};
    end
    case (o)
      3'd0: return x * y;
      3'd1: begin p = {{64{x[63]}}, x} * {{64{y[63]}}, y}; return p[127:64]; end
      3'd2: begin p = {{64{x[63]}}, x} * {64'd0, y};       return p[127:64]; end
      3'd3: begin p = {64'd0, x} * {64'd0, y};             return p[127:64]; end
      3'd4: return (y == 0) ? ALL1 : ov64 ? MIN64 : 64'(sx / sy);
      3'd5: return (y == 0) ? ALL1 : x / y;
      3'd6: return (y == 0) ? x : ov64 ? 64'd0 : 64'(sx % sy);
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // edges from acceptance (inclusive) until out_valid is first seen high
  function automatic int exp_lat(input logic [2:0] o, input logic w,
                                 input logic [63:0] x, input logic [63:0] y);
    bit ww, zero, ov;
    ww   = is_word(o, w);
    zero = ww ? (y[31:0] == 0) : (y == 0);
    ov   = (o == 3'd4 || o == 3'd6) &&
           (ww ? (x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF)
               : (x == MIN64 && y == ALL1));
    if (o >= 3'd4 && (zero || ov)) return 1;
    return (ww ? 32 : 64) + 1;
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return ALL1;
      2: return MIN64;
      3: return 64'($urandom_range(0, 20));
      4: return {$urandom, 32'h8000_0000};
      5: return {$urandom, 32'hFFFF_FFFF};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // monitor: latency on each rising out_valid, result on each handshake
  initial forever begin
    @(posedge clk);
    #2;
    if (rst) begin
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid: out_valid rose with nothing outstanding at cycle %0d", cyc);
        end else begin
          check("latency", 64'(cyc - sb[0].acc + 1), 64'(sb[0].lat));
        end
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("result", res, e.res);
      end
    end
    prev_valid = out_valid;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic issue(input logic [2:0] o, input logic w, input logic [63:0] x,
                       input logic [63:0] y, input bit push);
    int k = 0;
    while (!in_ready && k < 300) begin
      @(posedge clk); #1; k++;
    end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles", k);
      return;
    end
    op = o; word = w; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) sb.push_back('{model(o, w, x, y), cyc, exp_lat(o, w, x, y)});
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!out_valid && k < 200) begin
      @(posedge clk); #1; k++;
    end
    check("wait_valid", 64'(out_valid), 64'd1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((sb.size() != 0 || !in_ready) && k < 500) begin
      @(posedge clk); #1; k++;
    end
    check("drain_outstanding", 64'(sb.size()), 64'd0);
  endtask

  req_t dir[] = '{
    '{3'd0, 1'b0, 64'd7, -64'sd3},
    '{3'd3, 1'b0, ALL1, ALL1},
    '{3'd2, 1'b0, ALL1, 64'd2},
    '{3'd4, 1'b0, 64'd5, 64'd0},
    '{3'd7, 1'b0, 64'd5, 64'd0},
    '{3'd4, 1'b0, MIN64, ALL1},
    '{3'd6, 1'b0, MIN64, ALL1},
    '{3'd4, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2},
    '{3'd6, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2},
    '{3'd5, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1},
    '{3'd0, 1'b1, 64'h0000_0001_0001_0000, 64'h0000_0000_0000_8000},
    '{3'd7, 1'b1, 64'h1234_5678_8000_0001, 64'hABCD_0000_0000_0000},
    '{3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF},
    '{3'd1, 1'b1, MIN64, MIN64},
    '{3'd5, 1'b0, ALL1, 64'd3}
  };

  initial begin
    logic [63:0] exp_r;
    bit          saw_valid;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 3'd0; word = 1'b0; a = '0; b = '0;
    #3;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_res", res, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    foreach (dir[i]) issue(dir[i].op, dir[i].w, dir[i].a, dir[i].b, 1'b1);
    wait_idle();

    // backpressure
    out_ready = 1'b0;
    exp_r = model(3'd0, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_1003);
    issue(3'd0, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_1003, 1'b1);
    wait_valid();
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_res", res, exp_r);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("release_out_valid", 64'(out_valid), 64'd0);

    // flush ten edges into a divide
    issue(3'd4, 1'b0, 64'd1000, 64'd7, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", 64'(in_ready), 64'd1);
    saw_valid = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1;
    end
    check("flush_no_valid", 64'(saw_valid), 64'd0);

    // request alongside flush must be ignored
    op = 3'd0; word = 1'b0; a = 64'd3; b = 64'd3; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_req_in_ready", 64'(in_ready), 64'd1);
    issue(3'd0, 1'b0, 64'd6, 64'd7, 1'b1);
    wait_idle();

    // randomized traffic with random consumer stalls
    rand_ready = 1;
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  ro;
      logic        rw;
      logic [63:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      rw = 1'($urandom_range(0, 1));
      ra = rnd64();
      rb = rnd64();
      issue(ro, rw, ra, rb, 1'b1);
    end
    rand_ready = 0;
    #0 out_ready = 1'b1;
    wait_idle();

    // reset while the result is waiting
    out_ready = 1'b0;
    issue(3'd0, 1'b0, 64'd11, 64'd13, 1'b1);
    wait_valid();
    #2 rst = 1'b0;
    #1;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    check("rst_mid_res", res, 64'd0);
    sb.delete();
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    issue(3'd1, 1'b0, ALL1, 64'd5, 1'b1);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
